// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- write-back stage of the 5-stage MIPS pipeline.
//
// Holds the MEM/WB pipeline latch (stall/flush), drives the register-file
// write port and executes syscalls: print-int copies $a0 into the display
// register, exit halts the core until the next reset.
//
// Optional feature macro: WB_RETIRE_CNT_EN
//   defined   -> 'retired' counts retired instructions (wraps at 2^CNT_W)
//   undefined -> no counter is built, 'retired' is tied to 0
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall, flush        latch hold / latch bubble (flush wins over stall)
//   in_valid .. in_a0   instruction fields arriving from the memory stage
//   rf_we/waddr/wdata   register-file write port (combinational from latch)
//   disp, disp_upd      display register and its one-cycle update pulse
//   halted              core halted by the exit syscall
//   retired             retired-instruction count
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter logic [31:0] SYS_PRINT = 32'd1,
    parameter logic [31:0] SYS_EXIT  = 32'd10,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_ir,
    input  logic [31:0]      in_signal,
    input  logic [4:0]       in_dst,
    input  logic [31:0]      in_d,
    input  logic [31:0]      in_r,
    input  logic [31:0]      in_v0,
    input  logic [31:0]      in_a0,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [31:0]      disp,
    output logic             disp_upd,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    // Control-word bit positions.
    localparam int SIG_REGWRITE = 6;
    localparam int SIG_MEMREAD  = 4;
    localparam int SIG_SYSCALL  = 22;
    localparam int SIG_LINK     = 23;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] sig;
        logic [4:0]  dst;
        logic [31:0] d;
        logic [31:0] r;
        logic [31:0] v0;
        logic [31:0] a0;
    } mw_t;

    mw_t         mw_q, mw_d;
    state_t      state_q, state_d;
    logic        acted_q, acted_d;
    logic [31:0] disp_q, disp_d;
    logic        disp_upd_q, disp_upd_d;
    logic        sys_fire;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        mw_d       = mw_q;
        state_d    = state_q;
        disp_d     = disp_q;
        disp_upd_d = 1'b0;

        if (flush) begin
            mw_d = '0;
        end else if (!stall) begin
            mw_d.valid = in_valid;
            mw_d.pc    = in_pc;
            mw_d.ir    = in_ir;
            mw_d.sig   = in_signal;
            mw_d.dst   = in_dst;
            mw_d.d     = in_d;
            mw_d.r     = in_r;
            mw_d.v0    = in_v0;
            mw_d.a0    = in_a0;
        end

        // A syscall acts on its first un-stalled cycle in RUN, and only once.
        sys_fire = (state_q == ST_RUN) && mw_q.valid && mw_q.sig[SIG_SYSCALL]
                   && !stall && !acted_q;

        // The acted flag belongs to the latched instruction: it is cleared
        // whenever the latch takes a new instruction or a bubble.
        acted_d = (flush || !stall) ? 1'b0 : (acted_q | sys_fire);

        if (sys_fire && mw_q.v0 == SYS_EXIT) begin
            state_d = ST_HALT;
        end
        if (sys_fire && mw_q.v0 == SYS_PRINT) begin
            disp_d     = mw_q.a0;
            disp_upd_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            mw_q       <= '0;
            state_q    <= ST_RUN;
            acted_q    <= 1'b0;
            disp_q     <= '0;
            disp_upd_q <= 1'b0;
        end else begin
            mw_q       <= mw_d;
            state_q    <= state_d;
            acted_q    <= acted_d;
            disp_q     <= disp_d;
            disp_upd_q <= disp_upd_d;
        end
    end

    assign halted   = (state_q == ST_HALT);
    assign disp     = disp_q;
    assign disp_upd = disp_upd_q;

    // -------------------------------------------------------------------------
    // Register-file write port
    // -------------------------------------------------------------------------
    // Syscalls never write, $0 is never written, and a cycle with rst high
    // writes nothing so a reset aborts whatever sits in the latch.
    assign rf_we = mw_q.valid && mw_q.sig[SIG_REGWRITE] && !mw_q.sig[SIG_SYSCALL]
                   && (mw_q.dst != 5'd0) && !halted && !rst;

    assign rf_waddr = mw_q.dst;

    always_comb begin
        if (mw_q.sig[SIG_LINK]) begin
            rf_wdata = mw_q.pc + 32'd4;
        end else if (mw_q.sig[SIG_MEMREAD]) begin
            rf_wdata = mw_q.d;
        end else begin
            rf_wdata = mw_q.r;
        end
    end

    // The instruction word and unused control bits travel with the
    // instruction for debug visibility only.
    logic unused_latch_bits;
    assign unused_latch_bits = ^mw_q;

    // -------------------------------------------------------------------------
    // Retired-instruction counter
    // -------------------------------------------------------------------------
`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    // An instruction retires on the edge it leaves the latch un-stalled;
    // the exit syscall still counts because halted only rises after it.
    always_comb begin
        retired_d = retired_q;
        if (mw_q.valid && !stall && state_q == ST_RUN) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule
